// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: a registered output stage plus one skid register.
// All handshake outputs come from flops, so pout_ready never reaches pin_ready combinationally.
module pipe_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             pin_valid,
  output logic             pin_ready,
  input  logic [WIDTH-1:0] pin_data,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic [WIDTH-1:0] pout_data,
  output logic [1:0]       occupancy
);

  // Handshake: a beat moves when valid and ready are both high at a rising
  // edge; valid may drop and data may change freely while ready is low.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             pin_ready_q;
  logic             pout_valid_q;
  logic [1:0]       occ_q, occ_d;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = pin_valid & pin_ready_q;
  assign out_fire = pout_valid_q & pout_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            out_d   = pin_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            out_d = pin_data;
          end else if (in_fire) begin
            skid_d  = pin_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            out_d   = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    occ_d = 2'd0;
    case (state_d)
      BUSY:    occ_d = 2'd1;
      FULL:    occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  // Status flops are loaded from the next state so they track state_q exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      out_q        <= '0;
      skid_q       <= '0;
      pin_ready_q  <= 1'b1;
      pout_valid_q <= 1'b0;
      occ_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
      pin_ready_q  <= (state_d != FULL);
      pout_valid_q <= (state_d != EMPTY);
      occ_q        <= occ_d;
    end
  end

  assign pin_ready  = pin_ready_q;
  assign pout_valid = pout_valid_q;
  assign pout_data  = out_q;
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Bench for pipe_skid_buf: a capacity-2 queue model checked every cycle,
// plus directed scenarios with literal expectations and a random soak.
module tb_pipe_skid_buf;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         pin_valid;
  logic         pin_ready;
  logic [W-1:0] pin_data;
  logic         pout_valid;
  logic         pout_ready;
  logic [W-1:0] pout_data;
  logic [1:0]   occupancy;

  int unsigned n_total;
  int unsigned n_bad;
  logic        chk_en;
  logic [W-1:0] exp_q[$];

  pipe_skid_buf #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .pin_valid  (pin_valid),
    .pin_ready  (pin_ready),
    .pin_data   (pin_data),
    .pout_valid (pout_valid),
    .pout_ready (pout_ready),
    .pout_data  (pout_data),
    .occupancy  (occupancy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered queue holding at most two payloads.
  always @(posedge clk or posedge rst) begin : model
    logic inf;
    logic outf;
    if (rst) begin
      exp_q.delete();
    end else begin
      inf  = pin_valid && (exp_q.size() < 2);
      outf = (exp_q.size() > 0) && pout_ready;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (outf) void'(exp_q.pop_front());
        if (inf) exp_q.push_back(pin_data);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_pin_ready", 32'(pin_ready), 32'(exp_q.size() < 2));
      check("mdl_pout_valid", 32'(pout_valid), 32'(exp_q.size() > 0));
      check("mdl_occupancy", 32'(occupancy), 32'(exp_q.size()));
      if (exp_q.size() > 0) check("mdl_pout_data", pout_data, exp_q[0]);
    end
  end

  // Driver tasks
  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    pin_valid  = v;
    pin_data   = d;
    pout_ready = r;
    flush      = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic rdy, input logic vld,
                            input logic [1:0] occ, input logic [W-1:0] data, input logic chk_data);
    check({name, "_pin_ready"}, 32'(pin_ready), 32'(rdy));
    check({name, "_pout_valid"}, 32'(pout_valid), 32'(vld));
    check({name, "_occupancy"}, 32'(occupancy), 32'(occ));
    if (chk_data) check({name, "_pout_data"}, pout_data, data);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    chk_en  = 1'b0;
    rst     = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    expect_out("reset", 1'b1, 1'b0, 2'd0, 32'h0, 1'b1);
    step();
    step();
    rst    = 1'b0;
    chk_en = 1'b1;

    // Streaming with pout_ready high: one beat per cycle, one-cycle latency
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      step();
      expect_out("stream", 1'b1, 1'b1, 2'd1, W'(i), 1'b1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    expect_out("stream_drain", 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);

    // Backpressure fills the skid register, then drains in order
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    step();
    expect_out("bp_one", 1'b1, 1'b1, 2'd1, 32'hA, 1'b1);
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    step();
    expect_out("bp_full", 1'b0, 1'b1, 2'd2, 32'hA, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    expect_out("bp_hold", 1'b0, 1'b1, 2'd2, 32'hA, 1'b1);
    pout_ready = 1'b1;
    #1;
    check("no_comb_ready", 32'(pin_ready), 32'h0);
    step();
    expect_out("bp_out_a", 1'b1, 1'b1, 2'd1, 32'hB, 1'b1);
    step();
    expect_out("bp_out_b", 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);

    // Input offered while full is not taken until re-presented
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    step();
    step();
    expect_out("full_reject", 1'b0, 1'b1, 2'd2, 32'h11, 1'b1);
    drive(1'b0, 32'h33, 1'b1, 1'b0);
    step();
    expect_out("full_pop", 1'b1, 1'b1, 2'd1, 32'h22, 1'b1);
    drive(1'b1, 32'h33, 1'b1, 1'b0);
    step();
    expect_out("represent", 1'b1, 1'b1, 2'd1, 32'h33, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    expect_out("represent_drain", 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);

    // Flush beats simultaneous in_fire and out_fire
    drive(1'b1, 32'h44, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h66, 1'b1, 1'b1);
    step();
    expect_out("flush", 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    expect_out("flush_after", 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);

    // Asynchronous reset while busy
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    step();
    expect_out("pre_rst", 1'b1, 1'b1, 2'd1, 32'h77, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    expect_out("async_rst", 1'b1, 1'b0, 2'd0, 32'h0, 1'b1);
    step();
    rst = 1'b0;
    drive(1'b1, 32'h5, 1'b0, 1'b0);
    step();
    expect_out("post_rst", 1'b1, 1'b1, 2'd1, 32'h5, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    expect_out("post_rst_drain", 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);

    // Random soak against the queue model
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0));
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_buf.md
PIPE_SKID_BUF -- requirements
Module: pipe_skid_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port flush  input  1  synchronous pipeline flush request.
REQ-005 SHALL have port pin_valid  input  1  upstream payload valid.
REQ-006 SHALL have port pin_ready  output  1  buffer can accept; driven directly from a flop.
REQ-007 SHALL have port pin_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port pout_valid  output  1  downstream payload valid; driven directly from a flop.
REQ-009 SHALL have port pout_ready  input  1  downstream can accept.
REQ-010 SHALL have port pout_data  output  WIDTH  downstream payload; driven directly from the output register.
REQ-011 SHALL have port occupancy  output  2  entries held: 0, 1 or 2.

Function
REQ-012 SHALL define in_fire = pin_valid & pin_ready and out_fire = pout_valid & pout_ready.
REQ-013 SHALL hold two WIDTH-bit registers: out_reg, which drives pout_data, and skid_reg.
REQ-014 SHALL implement three states: EMPTY (occupancy 0), BUSY (1, out_reg valid), FULL (2, out_reg and skid_reg valid).
REQ-015 SHALL drive pin_ready = (state != FULL), pout_valid = (state != EMPTY) and occupancy from registered state only; no combinational path from pout_ready to pin_ready.
REQ-016 SHALL, in EMPTY, on in_fire load out_reg <- pin_data and go to BUSY; otherwise stay EMPTY.
REQ-017 SHALL, in BUSY with in_fire and out_fire, load out_reg <- pin_data and stay BUSY.
REQ-018 SHALL, in BUSY with in_fire and no out_fire, load skid_reg <- pin_data, hold out_reg and go to FULL.
REQ-019 SHALL, in BUSY with out_fire and no in_fire, go to EMPTY.
REQ-020 SHALL, in BUSY with neither fire, hold state and data.
REQ-021 SHALL, in FULL, not accept input (pin_ready=0); on out_fire load out_reg <- skid_reg and go to BUSY; otherwise hold.
REQ-022 SHALL give a latency of exactly 1 cycle from in_fire into EMPTY to pout_valid=1 with that payload.
REQ-023 SHALL sustain one transfer per cycle when pout_ready is held high.
REQ-024 SHALL deliver payloads in acceptance order with no loss or duplication.
REQ-025 SHALL keep pout_data and pout_valid stable while pout_valid=1 and pout_ready=0.
REQ-026 SHALL give flush priority over all transitions: on a clk edge with flush=1, state goes to EMPTY and any in_fire or out_fire in that cycle is ignored.
REQ-027 SHALL leave data register contents unspecified after flush; pout_valid=0 masks them.
REQ-028 SHALL not require pin_valid to be held, and SHALL not require pin_data to be stable, when pin_ready=0.

Reset
REQ-029 SHALL, while rst=1, force state EMPTY, pin_ready=1, pout_valid=0 and occupancy=0 immediately, independent of clk.
REQ-030 SHALL clear out_reg and skid_reg to 0 on reset, so pout_data=0.
REQ-031 SHALL, after rst is released mid-operation, discard all previously held entries and accept input on the first following edge.

Verification
REQ-032 SHALL cover: pout_ready=1, pin_valid=1 with data 1,2,3,4 on consecutive cycles -> pout_data 1,2,3,4 one cycle later each, pin_ready stays 1.
REQ-033 SHALL cover: pout_ready=0, push 0xA then 0xB -> occupancy 2, pin_ready=0, pout_data=0xA held; pout_ready=1 -> 0xA then 0xB out, pin_ready returns to 1 one cycle after the first out_fire.
REQ-034 SHALL cover: FULL with 0x11 and 0x22 held, pin_valid=1 with data 0x33 while pin_ready=0 -> 0x33 never appears on output until it is re-presented after pin_ready=1.
REQ-035 SHALL cover: FULL, flush=1 with pin_valid=1 and pout_ready=1 -> next cycle occupancy 0, pout_valid=0, pin_ready=1, no payload delivered.
REQ-036 SHALL cover: rst asserted between edges while BUSY -> pout_valid=0 and occupancy=0 before the next clk edge; after release, 0x5 pushed appears at output 1 cycle later.
REQ-037 SHALL cover: randomized pin_valid/pout_ready at 50% for 10000 cycles against a reference queue model -> order and data match, no combinational ready path.
